// File: rtl/load_ctrl_pkg.sv
// rtl/load_ctrl_pkg.sv - shared state encoding and data-type codes for the load sequencer
// Contents: one-hot state codes driven onto the receiver's state bus, the
// index of the RECV bit (the receiver's tready enable), and the 2-bit
// data-type codes shared with the stream receiver.
package load_ctrl_pkg;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_RECV  = 6'b000010,
    ST_CMD   = 6'b000100,
    ST_CHECK = 6'b001000,
    ST_DONE  = 6'b010000,
    ST_ERR   = 6'b100000
  } state_t;

  localparam int RECV_BIT = 1;

  localparam logic [1:0] DT_FEATURE   = 2'b00;
  localparam logic [1:0] DT_WEIGHT    = 2'b01;
  localparam logic [1:0] DT_BIAS      = 2'b10;
  localparam logic [1:0] DT_LEAKYRELU = 2'b11;

  // Phase index -> receiver data-type code.
  function automatic logic [1:0] phase_dtype(input logic [1:0] phase);
    case (phase)
      2'd0:    phase_dtype = DT_FEATURE;
      2'd1:    phase_dtype = DT_WEIGHT;
      2'd2:    phase_dtype = DT_BIAS;
      default: phase_dtype = DT_LEAKYRELU;
    endcase
  endfunction

endpackage

// File: rtl/load_phase_sel.sv
// rtl/load_phase_sel.sv - priority picker for the next enabled load phase
// Ports:
//   en         effective per-phase enable (bit0 feature .. bit3 leakyrelu)
//   cur        current phase index, signed; -1 selects the first enabled phase
//   next_phase lowest enabled phase strictly above cur
//   none_left  no enabled phase above cur
module load_phase_sel (
  input  logic [3:0]        en,
  input  logic signed [2:0] cur,
  output logic [1:0]        next_phase,
  output logic              none_left
);

  // Scan from the top down so the last hit is the lowest qualifying phase.
  always_comb begin
    next_phase = 2'd0;
    none_left  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) begin
        next_phase = 2'(i);
        none_left  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/load_ctrl.sv
// rtl/load_ctrl.sv - DMA-to-stream receive sequencer over feature/weight/bias/leakyrelu phases
// Ports:
//   sclk, s_rst_n              clock, synchronous active-low reset
//   start, abort               run pulse (IDLE only), forced return to IDLE
//   phase_en, phase_addrN/lenN per-phase enable, source address, beat count
//   cmd_valid/ready/addr/len   MM2S read command handshake
//   data_type, state           receiver phase type and one-hot state
//   write_finish, rx_beat      receiver last-beat pulse and delivered-beat strobe
//   busy, done, err, err_phase status
module load_ctrl
  import load_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        phase_en,
  input  logic [ADDR_W-1:0] phase_addr0,
  input  logic [ADDR_W-1:0] phase_addr1,
  input  logic [ADDR_W-1:0] phase_addr2,
  input  logic [ADDR_W-1:0] phase_addr3,
  input  logic [LEN_W-1:0]  phase_len0,
  input  logic [LEN_W-1:0]  phase_len1,
  input  logic [LEN_W-1:0]  phase_len2,
  input  logic [LEN_W-1:0]  phase_len3,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic [1:0]        data_type,
  output logic [5:0]        state,
  input  logic              write_finish,
  input  logic              rx_beat,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_phase
);

  state_t            st;
  logic [3:0]        en_q;
  logic [ADDR_W-1:0] addr_q [4];
  logic [LEN_W-1:0]  len_q  [4];
  logic [1:0]        cur;
  logic [LEN_W:0]    cnt;    // one spare bit so an overrun is visible

  logic [ADDR_W-1:0] addr_in [4];
  logic [LEN_W-1:0]  len_in  [4];
  logic [3:0]        start_en;
  logic [3:0]        sel_en;
  logic signed [2:0] sel_cur;
  logic [1:0]        sel_next;
  logic              sel_none;
  logic [ADDR_W-1:0] nxt_addr;
  logic [LEN_W-1:0]  nxt_len;
  logic [LEN_W:0]    cnt_nxt;
  logic [LEN_W:0]    len_cur;

  assign addr_in[0] = phase_addr0;
  assign addr_in[1] = phase_addr1;
  assign addr_in[2] = phase_addr2;
  assign addr_in[3] = phase_addr3;
  assign len_in[0]  = phase_len0;
  assign len_in[1]  = phase_len1;
  assign len_in[2]  = phase_len2;
  assign len_in[3]  = phase_len3;

  // A zero-length phase is treated as disabled.
  assign start_en = phase_en & {phase_len3 != '0, phase_len2 != '0,
                                phase_len1 != '0, phase_len0 != '0};

  // In IDLE the picker sees the live configuration (it is latched on the same
  // edge); afterwards it walks the latched enables from the current phase.
  assign sel_en   = (st == ST_IDLE) ? start_en : en_q;
  assign sel_cur  = (st == ST_IDLE) ? 3'sb111 : $signed({1'b0, cur});
  assign nxt_addr = (st == ST_IDLE) ? addr_in[sel_next] : addr_q[sel_next];
  assign nxt_len  = (st == ST_IDLE) ? len_in[sel_next]  : len_q[sel_next];
  assign cnt_nxt  = cnt + {{LEN_W{1'b0}}, rx_beat};
  assign len_cur  = {1'b0, len_q[cur]};
  assign state    = st;

  load_phase_sel u_sel (
    .en         (sel_en),
    .cur        (sel_cur),
    .next_phase (sel_next),
    .none_left  (sel_none)
  );

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      st        <= ST_IDLE;
      en_q      <= '0;
      addr_q    <= '{default: '0};
      len_q     <= '{default: '0};
      cur       <= 2'd0;
      cnt       <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      data_type <= DT_FEATURE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_phase <= 2'd0;
    end else if (abort) begin
      st        <= ST_IDLE;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) begin
            en_q   <= start_en;
            addr_q <= addr_in;
            len_q  <= len_in;
            busy   <= 1'b1;
            if (sel_none) begin
              st <= ST_DONE;
            end else begin
              st        <= ST_CMD;
              cur       <= sel_next;
              data_type <= phase_dtype(sel_next);
              cmd_valid <= 1'b1;
              cmd_addr  <= nxt_addr;
              cmd_len   <= nxt_len;
              cnt       <= '0;
            end
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            st        <= ST_RECV;
          end
        end
        ST_RECV: begin
          cnt <= cnt_nxt;
          if (write_finish) begin
            st <= ST_CHECK;
          end else if (cnt_nxt > len_cur) begin
            st        <= ST_ERR;
            err       <= 1'b1;
            err_phase <= cur;
          end
        end
        ST_CHECK: begin
          // rx_beat lags write_finish by one cycle, so the final beat lands here.
          cnt <= cnt_nxt;
          if (cnt_nxt != len_cur) begin
            st        <= ST_ERR;
            err       <= 1'b1;
            err_phase <= cur;
          end else if (sel_none) begin
            st <= ST_DONE;
          end else begin
            st        <= ST_CMD;
            cur       <= sel_next;
            data_type <= phase_dtype(sel_next);
            cmd_valid <= 1'b1;
            cmd_addr  <= nxt_addr;
            cmd_len   <= nxt_len;
            cnt       <= '0;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        ST_ERR: begin
          // Held until abort.
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_ctrl.md
# load_ctrl

Sequencer for the DMA-to-stream receive path. It steps through up to four load phases in fixed order: feature, weight, bias, leakyrelu. For each enabled phase it issues one MM2S read command, drives `data_type` and `state` into the stream receiver, and counts delivered beats. A phase ends on the receiver's `write_finish`; the block then checks the beat count against the programmed length. It sits between the main control/register block and the stream receiver.

## Interface
- `ADDR_W`, 32: DMA byte-address width.
- `LEN_W`, 16: phase length width, in 64-bit beats.

Ports:
- `sclk`  in  1  clock.
- `s_rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `abort`  in  1  forces IDLE from any state next cycle; also clears `err`.
- `phase_en`  in  4  enable per phase; bit0 feature, bit1 weight, bit2 bias, bit3 leakyrelu.
- `phase_addr0..3`  in  ADDR_W each  source address per phase.
- `phase_len0..3`  in  LEN_W each  beats per phase.
- `cmd_valid`  out  1  DMA command valid.
- `cmd_ready`  in  1  DMA command accept.
- `cmd_addr`  out  ADDR_W  command address.
- `cmd_len`  out  LEN_W  command length, in beats.
- `data_type`  out  2  to receiver: 00 feature, 01 weight, 10 bias, 11 leakyrelu.
- `state`  out  6  one-hot to receiver; bit1 = RECV (receiver tready enable).
- `write_finish`  in  1  receiver pulse on the last beat.
- `rx_beat`  in  1  OR of the receiver's four `*_vld` outputs.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when all phases complete.
- `err`  out  1  sticky error flag.
- `err_phase`  out  2  phase that raised `err`.

## Operation
- States, one-hot on `state`: IDLE=000001, RECV=000010, CMD=000100, CHECK=001000, DONE=010000, ERR=100000.
- **IDLE + start**: latch `phase_en`, all addresses and all lengths. Effective enable = `phase_en[i]` && `phase_len[i] != 0`. Lowest enabled phase selected → CMD. No phase enabled → DONE.
- **CMD**:
  - `cmd_valid`=1; `cmd_addr`/`cmd_len` are the selected phase's values, stable until `cmd_ready`.
  - `data_type` = selected phase.
  - Beat counter cleared.
  - `cmd_valid && cmd_ready` → RECV.
- **RECV**:
  - `rx_beat` increments the counter.
  - `write_finish` → CHECK.
  - Counter reaching `len` with `rx_beat` high and no `write_finish` seen yet → no change; overrun is caught in CHECK.
  - Counter exceeding `len` → ERR immediately.
- **CHECK** (one cycle): absorbs the trailing `rx_beat`, which arrives 1 cycle after `write_finish`.
  - Count including that beat equals `len` → next enabled phase → CMD; none left → DONE.
  - Count differs → ERR.
- **DONE**: `done`=1 for one cycle → IDLE.
- **ERR**: `err`=1 and `err_phase` latched. Stays in ERR until `abort`; `start` is ignored.
- `data_type` holds its value through RECV and CHECK; it changes only on entry to CMD.
- `abort` takes priority over all transitions, including a simultaneous `cmd_ready`. It drops `cmd_valid` immediately. Software resets the DMA after an abort.

## Timing
- Reset values: `state`=000001, `data_type`=00, `cmd_valid`=0, `cmd_addr`=0, `cmd_len`=0, `busy`=0, `done`=0, `err`=0, `err_phase`=00. Beat counter = 0.
- All outputs are registered.
- `start` → `cmd_valid` high: 1 cycle.
- `cmd_ready` handshake → `state`=RECV: next cycle.
- Last handshake in the receiver → `write_finish` (+1) → CHECK (+2) → next CMD or DONE (+3).
- Phase-to-phase gap is 2 cycles plus DMA command latency.
- Reset asserted mid-operation: all registers return to reset values at the next edge; latched configuration is discarded.

## Structure
- Package `load_ctrl_pkg` holds:
  - State one-hot constants and the RECV bit index (1).
  - Data-type codes (00/01/10/11), shared with the stream receiver.
- Sub-module `load_phase_sel`: combinational priority picker. Inputs: 4-bit effective enable and current phase index. Outputs: next enabled phase above the current one and a `none_left` flag. Reused for the start selection with current = −1.

## Test plan
- All four enabled, lengths 4/8/1/2: four commands with matching addr/len; `data_type` steps 00, 01, 10, 11; single `done`; `err`=0.
- `phase_en`=0101, `phase_len1`=8: only feature and bias commands issued; `data_type` never 01 or 11.
- `phase_en`=0000, or all lengths 0: `done` pulses 2 cycles after `start`; no `cmd_valid`.
- Weight length 8, stream delivers 7 beats with tlast on beat 7: ERR at CHECK, `err_phase`=01, `state`=100000. `start` ignored until `abort`.
- `cmd_ready` held low 10 cycles: `cmd_valid`, `cmd_addr`, `cmd_len` stable throughout. `abort` in cycle 5: next cycle `state`=IDLE, `cmd_valid`=0.
- `s_rst_n` low for 1 cycle mid-RECV: all outputs at reset values on the following cycle; a new `start` runs cleanly.
